mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter BIT_WIDTH, default 32, data and address width.
REQ-002 Parameter DEPTH_LOG2, default 5, log2 of the number of words in the attached memory (32 words).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock, shared with the attached memory.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  requester presents a transaction.
REQ-007 req_ready  out  1  block accepts the transaction this cycle.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_addr  in  BIT_WIDTH  byte address.
REQ-010 req_wdata  in  BIT_WIDTH  store data.
REQ-011 resp_valid  out  1  response available.
REQ-012 resp_ready  in  1  requester consumes the response.
REQ-013 resp_rdata  out  BIT_WIDTH  load data; 0 for stores and errors.
REQ-014 resp_err  out  1  misaligned or out-of-range address.
REQ-015 mem_addr  out  BIT_WIDTH  word index to the memory address port; upper bits 0.
REQ-016 mem_wdata  out  BIT_WIDTH  memory write data.
REQ-017 mem_we  out  1  memory write enable.
REQ-018 mem_rdata  in  BIT_WIDTH  memory read data; registered, valid one cycle after the memory samples a non-write address.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, CAPTURE and RESP, with one transaction in flight at most.
REQ-020 req_ready SHALL be 1 only in IDLE (combinational from state).
REQ-021 Acceptance SHALL occur at a rising edge with req_valid=1 and req_ready=1, and the block SHALL latch req_we, req_addr and req_wdata at that edge.
REQ-022 An address SHALL be an error if req_addr[1:0]!=0 or req_addr[BIT_WIDTH-1:DEPTH_LOG2+2]!=0.
REQ-023 On acceptance with an error: IDLE->RESP, resp_err=1, resp_rdata=0, and mem_we SHALL never assert for that transaction.
REQ-024 On acceptance with a valid address: IDLE->ISSUE, mem_addr=req_addr[DEPTH_LOG2+1:2], mem_wdata=req_wdata, and mem_we=req_we, all registered.
REQ-025 ISSUE SHALL last exactly one cycle with a store: ISSUE->RESP, and mem_we SHALL clear at the ISSUE exit edge so that exactly one memory write occurs.
REQ-026 ISSUE SHALL last exactly one cycle with a load: ISSUE->CAPTURE, with mem_we=0.
REQ-027 CAPTURE SHALL last one cycle, and resp_rdata SHALL load mem_rdata at the CAPTURE exit edge, followed by CAPTURE->RESP.
REQ-028 Latency SHALL be measured from the acceptance edge to the resp_valid rise: load 3 edges, store 2 edges, error 1 edge.
REQ-029 In RESP, resp_valid=1 and resp_rdata/resp_err SHALL be held stable until a rising edge with resp_ready=1, then RESP->IDLE.
REQ-030 resp_ready asserted outside RESP SHALL be ignored.
REQ-031 resp_ready=1 in the first RESP cycle SHALL complete the response in that one cycle, with no bubble beyond the return to IDLE.
REQ-032 mem_addr and mem_wdata SHALL hold their last values outside ISSUE/CAPTURE, and mem_we SHALL be 0 in all states except ISSUE.
REQ-033 req_valid/req_* changes outside IDLE SHALL NOT affect the in-flight transaction.
REQ-034 Back-to-back transactions: a new request SHALL be accepted on the first IDLE cycle after RESP completes, and a load following a store to the same address SHALL return the stored data.

Reset
REQ-035 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, mem_we=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0 and mem_wdata=0.
REQ-036 Reset during ISSUE SHALL abort the transaction with no response issued; a store is not written if rst_n falls before the ISSUE exit edge.
REQ-037 After rst_n rises, req_ready SHALL be 1 on the first cycle.

Verification
REQ-038 Store then load: store addr 0x0000_0010 data 0xDEAD_BEEF -> mem_we high for exactly 1 cycle with mem_addr=4, resp_valid 2 edges after acceptance, then load 0x10 -> resp_rdata=0xDEAD_BEEF 3 edges after acceptance, resp_err=0.
REQ-039 Misaligned and out-of-range addresses: load 0x0000_0006 and store 0x0000_0080 -> resp_err=1, resp_rdata=0, resp_valid 1 edge after acceptance, mem_we never 1.
REQ-040 Response backpressure: resp_ready held 0 for 5 cycles in RESP -> resp_valid, resp_rdata and resp_err stable, req_ready=0 throughout, and the response completes on the edge where resp_ready=1.
REQ-041 Request stimulus during busy: req_valid held 1 with changing req_addr during ISSUE/CAPTURE -> no acceptance and the in-flight mem_addr is unchanged.
REQ-042 Reset mid-store: rst_n pulsed low during ISSUE for store 0x08 data 0x1234_5678 -> mem_we drops immediately, no response, and a subsequent load 0x08 returns the prior contents.
REQ-043 Full sweep: write pattern i*0x0101_0101 to all 32 words, then read all 32 back -> every word matches, boundary word 31 (addr 0x7C) valid, addr 0x80 -> resp_err=1.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Requester and memory-side bus bundle for mem_access_ctrl.
// The slave modport is the controller's view; master is the requester/memory environment.
interface mem_access_ctrl_if #(
  parameter int unsigned BIT_WIDTH = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [BIT_WIDTH-1:0] req_addr;
  logic [BIT_WIDTH-1:0] req_wdata;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [BIT_WIDTH-1:0] resp_rdata;
  logic                 resp_err;
  logic [BIT_WIDTH-1:0] mem_addr;
  logic [BIT_WIDTH-1:0] mem_wdata;
  logic                 mem_we;
  logic [BIT_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller in front of a registered-read word memory.
// Validates byte addresses, drives one memory access, and returns a held response.
module mem_access_ctrl #(
  parameter int unsigned BIT_WIDTH  = 32,
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_ctrl_if.slave bus
);

  localparam int unsigned IDX_LO = 2;
  localparam int unsigned IDX_HI = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_is_store;
  logic                 w_is_store_nxt;
  logic [BIT_WIDTH-1:0] r_mem_addr;
  logic [BIT_WIDTH-1:0] w_mem_addr_nxt;
  logic [BIT_WIDTH-1:0] r_mem_wdata;
  logic [BIT_WIDTH-1:0] w_mem_wdata_nxt;
  logic                 r_mem_we;
  logic                 w_mem_we_nxt;
  logic                 r_resp_valid;
  logic                 w_resp_valid_nxt;
  logic                 r_resp_err;
  logic                 w_resp_err_nxt;
  logic [BIT_WIDTH-1:0] r_resp_rdata;
  logic [BIT_WIDTH-1:0] w_resp_rdata_nxt;
  logic                 w_addr_err;

  // Misaligned byte address or word index beyond the memory depth
  assign w_addr_err = (bus.req_addr[1:0] != 2'b00) ||
                      (bus.req_addr[BIT_WIDTH-1:DEPTH_LOG2+2] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_is_store   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_is_store   <= w_is_store_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_is_store_nxt   = r_is_store;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_mem_we_nxt     = 1'b0;
    w_resp_valid_nxt = r_resp_valid;
    w_resp_err_nxt   = r_resp_err;
    w_resp_rdata_nxt = r_resp_rdata;

    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_resp_rdata_nxt = '0;
          w_resp_err_nxt   = 1'b0;
          if (w_addr_err) begin
            w_state_nxt      = RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
          end else begin
            w_state_nxt     = ISSUE;
            w_is_store_nxt  = bus.req_we;
            w_mem_addr_nxt  = BIT_WIDTH'(bus.req_addr[IDX_HI:IDX_LO]);
            w_mem_wdata_nxt = bus.req_wdata;
            w_mem_we_nxt    = bus.req_we;
          end
        end
      end
      // Memory samples the address at this state's exit edge; a store completes there
      ISSUE: begin
        if (r_is_store) begin
          w_state_nxt      = RESP;
          w_resp_valid_nxt = 1'b1;
        end else begin
          w_state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        w_state_nxt      = RESP;
        w_resp_valid_nxt = 1'b1;
        w_resp_rdata_nxt = bus.mem_rdata;
      end
      RESP: begin
        if (bus.resp_ready) begin
          w_state_nxt      = IDLE;
          w_resp_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_we     = r_mem_we;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a registered-read memory model.
module tb_mem_access_ctrl;

  localparam int unsigned BW  = 32;
  localparam int unsigned DL2 = 5;
  localparam int unsigned NW  = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.BIT_WIDTH(BW)) bus ();

  mem_access_ctrl #(.BIT_WIDTH(BW), .DEPTH_LOG2(DL2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [BW-1:0] mem_q  [NW];
  logic [BW-1:0] shadow [NW];
  int unsigned   we_cnt = 0;
  int            n_checks = 0;
  int            n_pass   = 0;

  // Memory: write when enabled, otherwise registered read of the presented index
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem_q[bus.mem_addr[DL2-1:0]] <= bus.mem_wdata;
      we_cnt <= we_cnt + 1;
    end else begin
      bus.mem_rdata <= mem_q[bus.mem_addr[DL2-1:0]];
    end
  end

  task automatic check(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic txn(input logic we, input logic [BW-1:0] addr, input logic [BW-1:0] wdata,
                     input int exp_lat, input logic exp_err, input logic [BW-1:0] exp_rdata,
                     input int hold, input logic poke);
    int unsigned   we0;
    int            lat;
    logic [BW-1:0] exp_idx;
    exp_idx = BW'(addr[DL2+1:2]);
    @(negedge clk);
    check("req_ready_idle", BW'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.resp_ready = poke;
    we0 = we_cnt;
    @(posedge clk); #1;
    if (!poke) begin
      bus.req_valid = 1'b0;
      bus.req_addr  = 32'hFFFF_FFF3;
    end
    lat = 1;
    while (!bus.resp_valid && lat < 8) begin
      if (poke) begin
        check("busy_mem_addr", bus.mem_addr, exp_idx);
        check("busy_req_ready", BW'(bus.req_ready), 32'd0);
        bus.req_addr = bus.req_addr + 32'h14;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    check("latency", BW'(lat), BW'(exp_lat));
    check("resp_err", BW'(bus.resp_err), BW'(exp_err));
    check("resp_rdata", bus.resp_rdata, exp_rdata);
    check("mem_we_count", BW'(we_cnt - we0), (we && !exp_err) ? 32'd1 : 32'd0);
    if (!exp_err) check("mem_addr", bus.mem_addr, exp_idx);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", BW'(bus.resp_valid), 32'd1);
      check("hold_rdata", bus.resp_rdata, exp_rdata);
      check("hold_err", BW'(bus.resp_err), BW'(exp_err));
      check("hold_req_ready", BW'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("resp_done_valid", BW'(bus.resp_valid), 32'd0);
    check("resp_done_ready", BW'(bus.req_ready), 32'd1);
    if (we && !exp_err) shadow[exp_idx[DL2-1:0]] = wdata;
  endtask

  initial begin
    int unsigned we0;
    for (int i = 0; i < int'(NW); i++) begin
      mem_q[i]  = '0;
      shadow[i] = '0;
    end
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    bus.mem_rdata  = '0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", BW'(bus.resp_valid), 32'd0);
    check("rst_resp_err", BW'(bus.resp_err), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_mem_we", BW'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_req_ready", BW'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Store then load the same word
    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 2, 1'b0, 32'h0, 0, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);

    // Misaligned and out-of-range
    txn(1'b0, 32'h06, 32'h0, 1, 1'b1, 32'h0, 0, 1'b0);
    txn(1'b1, 32'h80, 32'h5555_AAAA, 1, 1'b1, 32'h0, 0, 1'b0);
    txn(1'b0, 32'h1000_0000, 32'h0, 1, 1'b1, 32'h0, 0, 1'b0);

    // Backpressure, then busy-time request noise
    txn(1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 5, 1'b0);
    txn(1'b1, 32'h0C, 32'h0BAD_F00D, 2, 1'b0, 32'h0, 0, 1'b1);
    txn(1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 2, 1'b1);

    // Reset while a store sits in ISSUE must not write it
    txn(1'b1, 32'h08, 32'hCAFE_0008, 2, 1'b0, 32'h0, 0, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h08;
    bus.req_wdata = 32'h1234_5678;
    we0 = we_cnt;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rst_issue_mem_we", BW'(bus.mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_mem_we", BW'(bus.mem_we), 32'd0);
    check("rst_async_resp_valid", BW'(bus.resp_valid), 32'd0);
    check("rst_async_mem_addr", bus.mem_addr, 32'd0);
    check("rst_async_mem_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk); #1;
    check("rst_no_write", BW'(we_cnt - we0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_after_resp_valid", BW'(bus.resp_valid), 32'd0);
    check("rst_after_req_ready", BW'(bus.req_ready), 32'd1);
    txn(1'b0, 32'h08, 32'h0, 3, 1'b0, 32'hCAFE_0008, 0, 1'b0);

    // Full sweep of the memory
    for (int i = 0; i < int'(NW); i++)
      txn(1'b1, BW'(i * 4), BW'(i) * 32'h0101_0101, 2, 1'b0, 32'h0, 0, 1'b0);
    for (int i = 0; i < int'(NW); i++)
      txn(1'b0, BW'(i * 4), 32'h0, 3, 1'b0, BW'(i) * 32'h0101_0101, 0, 1'b0);
    txn(1'b0, 32'h7C, 32'h0, 3, 1'b0, shadow[31], 0, 1'b0);
    txn(1'b0, 32'h80, 32'h0, 1, 1'b1, 32'h0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
